// File: rtl/dynamic_add_ctrl_pkg.sv
// Shared definitions for the dynamic-completion adder wrapper.
//
// Contents:
//   state_t       - controller state encoding (ST_IDLE, ST_WAIT, ST_DONE)
//   count_width() - width of run-length / cycle-count fields for an N-bit adder
//   chain_len()   - worst-case ripple length given the longest propagate run
//   wait_cycles() - clock cycles needed for a chain to settle at SPC stages/cycle
package dynamic_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Run lengths span 0..N inclusive, hence N+1 distinct values.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // A carry born at the bit below a propagate run travels through the run
    // plus the bit that generates it; it can never exceed the adder width.
    function automatic int chain_len(input int run, input int n);
        return ((run + 1) > n) ? n : (run + 1);
    endfunction

    // Ceiling division of the chain length by the stages settled per cycle.
    // Always at least 1 because the chain length is at least 1.
    function automatic int wait_cycles(input int run, input int n, input int spc);
        return (chain_len(run, n) + spc - 1) / spc;
    endfunction

endpackage

// File: rtl/dynamic_add_ctrl_p_run_len.sv
// Longest run of consecutive ones in a propagate vector.
//
// Ports:
//   P - N-bit propagate vector from the adder
//   R - length of the longest run of 1s in P, range 0..N
module p_run_len
    import dynamic_add_ctrl_pkg::*;
#(
    parameter  int N  = 16,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  P,
    output logic [CW-1:0] R
);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cur;
    logic [CW-1:0] best;

    // Scan LSB to MSB keeping the current run and the best seen so far.
    always_comb begin
        cur  = '0;
        best = '0;
        for (int i = 0; i < N; i++) begin
            if (P[i]) begin
                cur = cur + ONE;
            end else begin
                cur = '0;
            end
            if (cur > best) begin
                best = cur;
            end
        end
        R = best;
    end
endmodule

// File: rtl/dynamic_add_ctrl_rca.sv
// Ripple-carry adder built from full-adder cells.
//
// FA ports:
//   a, b, cin - operand bits and carry in
//   s, cout   - sum bit and carry out
//   p         - propagate (a ^ b)
// RCA ports:
//   A, B      - N-bit operands
//   Cin       - carry in
//   S, Cout   - N-bit sum and carry out
//   P         - per-bit propagate vector, used to estimate settle time
module FA (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout,
    output logic p
);
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (p & cin);
endmodule

module RCA #(
    parameter int N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic [N-1:0] P
);
    logic [N:0] carry;

    assign carry[0] = Cin;
    assign Cout     = carry[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        FA u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (S[i]),
            .cout (carry[i+1]),
            .p    (P[i])
        );
    end
endmodule

// File: rtl/dynamic_add_ctrl.sv
// Clocked wrapper around a ripple-carry adder with data-dependent completion.
// Operands are registered, the adder settles for a number of cycles derived
// from the longest carry-propagate run, and the result is then captured and
// offered downstream.
//
// Parameters:
//   N   - operand width
//   SPC - ripple stages settled per clock cycle (must be >= 1)
// Ports:
//   clk, rst_n          - rising-edge clock, async active-low reset
//   in_valid, in_ready  - upstream operand handshake
//   A, B, Cin           - operands and carry in
//   out_valid, out_ready- downstream result handshake
//   S, Cout             - registered sum and carry out
//   cycles              - wait cycles used for the held result
module dynamic_add_ctrl
    import dynamic_add_ctrl_pkg::*;
#(
    parameter  int N   = 16,
    parameter  int SPC = 4,
    localparam int CW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic          Cin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  S,
    output logic          Cout,
    output logic [CW-1:0] cycles
);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state;
    state_t        state_next;

    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic          op_cin;
    logic [CW-1:0] counter;

    logic [N-1:0]  rca_s;
    logic          rca_cout;
    logic [N-1:0]  rca_p;
    logic [CW-1:0] run_len;
    logic [CW-1:0] wait_w;

    logic          accept;
    logic          finish;

    RCA #(.N(N)) u_rca (
        .A    (op_a),
        .B    (op_b),
        .Cin  (op_cin),
        .S    (rca_s),
        .Cout (rca_cout),
        .P    (rca_p)
    );

    p_run_len #(.N(N)) u_run (
        .P (rca_p),
        .R (run_len)
    );

    // Only depends on the operand registers, so it is stable throughout WAIT.
    assign wait_w = CW'(wait_cycles(int'(run_len), N, SPC));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (counter == wait_w) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            op_cin  <= 1'b0;
            counter <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            cycles  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_a    <= A;
                op_b    <= B;
                op_cin  <= Cin;
                counter <= ONE;
            end else if (state == ST_WAIT) begin
                counter <= counter + ONE;
                if (finish) begin
                    S      <= rca_s;
                    Cout   <= rca_cout;
                    cycles <= wait_w;
                end
            end
        end
    end
endmodule

// File: tb/tb_dynamic_add_ctrl.sv
module tb_dynamic_add_ctrl;
    localparam int N   = 16;
    localparam int SPC = 4;
    localparam int CW  = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  A = '0;
    logic [N-1:0]  B = '0;
    logic          Cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  S;
    logic          Cout;
    logic [CW-1:0] cycles;

    int tests = 0;
    int fails = 0;

    dynamic_add_ctrl #(.N(N), .SPC(SPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Longest run of ones by repeated self-AND with a shifted copy: each
    // iteration shortens every run by one, so the count is the longest run.
    function automatic int ref_wait(input logic [N-1:0] p);
        logic [N-1:0] x;
        int r;
        int l;
        x = p;
        r = 0;
        while (x != '0) begin
            x = x & (x >> 1);
            r++;
        end
        l = (r + 1 > N) ? N : r + 1;
        return (l + SPC - 1) / SPC;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_S"}, 32'(S), 32'd0);
        check({tag, "_Cout"}, 32'(Cout), 32'd0);
        check({tag, "_cycles"}, 32'(cycles), 32'd0);
    endtask

    // One full transaction: accept, wait, hold for 'hold' cycles, handoff.
    // 'noisy' keeps in_valid high with changing operands after the accept.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c, input int hold, input bit noisy);
        logic [N:0] exp_sum;
        int exp_w;
        int lat;
        exp_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        exp_w   = ref_wait(a ^ b);

        @(negedge clk);
        check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
        A = a; B = b; Cin = c; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // Accept edge has passed; operands changing now must not matter.
        in_valid = noisy;
        A = N'($urandom); B = N'($urandom); Cin = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (noisy) begin
                A = N'($urandom); B = N'($urandom);
            end
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_w));
        check({tag, "_S"}, 32'(S), 32'(exp_sum[N-1:0]));
        check({tag, "_Cout"}, 32'(Cout), 32'(exp_sum[N]));
        check({tag, "_cycles"}, 32'(cycles), 32'(exp_w));
        check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (noisy) begin
                A = N'($urandom); B = N'($urandom);
            end
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_S"}, 32'(S), 32'(exp_sum[N-1:0]));
            check({tag, "_hold_Cout"}, 32'(Cout), 32'(exp_sum[N]));
            check({tag, "_hold_cycles"}, 32'(cycles), 32'(exp_w));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_after_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_after_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state, checked while reset is held and after release.
        #2;
        check_reset_vals("rst_hold");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_rel");

        // Directed cases.
        do_op("full_chain", 16'h9C94, 16'h636A, 1'b1, 1, 1'b0);
        do_op("zeros",      16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        do_op("all_prop",   16'hFFFF, 16'h0000, 1'b1, 1, 1'b0);
        do_op("backpress",  16'h00FF, 16'h0001, 1'b0, 5, 1'b1);

        // Reset two cycles into a 4-cycle wait.
        @(negedge clk);
        A = 16'h9C94; B = 16'h636A; Cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_wait_no_valid", 32'(out_valid), 32'd0);
        end
        check("rst_wait_idle", 32'(in_ready), 32'd1);

        // Random sweep.
        for (int k = 0; k < 1000; k++) begin
            do_op("rand", N'($urandom), N'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
